// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table access controller.
package bht_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD_RD = 2'd1,
        UPD_WR = 2'd2
    } bht_state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Pending-update FIFO of {addr, taken} entries with a registered head.
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic [AW-1:0]          push_addr,
    input  logic                   push_taken,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [AW-1:0]          head_addr,
    output logic                   head_taken
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW:0]   mem_q [DEPTH];
    logic [AW:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [AW:0]   head_q, head_d;
    logic          do_push, do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full       = count_q[PW];
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_addr  = head_q[AW:1];
    assign head_taken = head_q[0];

    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {push_addr, push_taken};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        head_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/bht_access_ctrl.sv
// Single-port BHT sequencer: arbitrates fetch lookups against queued resolution
// updates. Define BHT_FWD_EN to forward the counter being written to a matching lookup.
module bht_access_ctrl
    import bht_pkg::*;
#(
    parameter int unsigned LOWER      = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             lk_valid,
    input  logic [LOWER-1:0] lk_addr,
    output logic             lk_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [LOWER-1:0] upd_addr,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [LOWER-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             busy
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    bht_state_e       state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [1:0]       ctr_q, ctr_d;
    logic             run_q, run_d;
    logic             pred_valid_q, pred_valid_d;
    logic             fwd_q, fwd_d;
    logic             fwd_taken_q, fwd_taken_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic [LOWER-1:0] head_addr;
    logic             head_taken;
    logic             force_upd, lk_acc, fwd_acc;
    logic [1:0]       wr_ctr;

    // run_q keeps every handshake output low until the first edge after reset.
    assign run_d     = 1'b1;
    assign upd_ready = run_q & ~fifo_full;
    assign fifo_push = upd_valid & upd_ready;

    bht_upd_fifo #(
        .AW    (LOWER),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (fifo_push),
        .push_addr  (upd_addr),
        .push_taken (upd_taken),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_addr  (head_addr),
        .head_taken (head_taken)
    );

    assign force_upd = (starve_q == SW'(STARVE_MAX)) | fifo_full;
    assign wr_ctr    = sat_update(ctr_q, head_taken);

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        lk_ready  = 1'b0;
        lk_acc    = 1'b0;
        fwd_acc   = 1'b0;
        fifo_pop  = 1'b0;
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (run_q) begin
                    lk_ready = ~force_upd;
                    if (lk_valid && !force_upd) begin
                        lk_acc   = 1'b1;
                        tbl_en   = 1'b1;
                        tbl_addr = lk_addr;
                    end else if (!fifo_empty) begin
                        tbl_en   = 1'b1;
                        tbl_addr = head_addr;
                        state_d  = UPD_RD;
                    end
                end
            end
            UPD_RD: begin
                ctr_d   = tbl_rdata;
                state_d = UPD_WR;
            end
            UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = head_addr;
                tbl_wdata = wr_ctr;
                fifo_pop  = 1'b1;
                state_d   = IDLE;
`ifdef BHT_FWD_EN
                lk_ready = (lk_addr == head_addr);
                fwd_acc  = lk_valid & lk_ready;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = fwd_acc ? SW'(1) : '0;
        end else if (fifo_empty) begin
            starve_d = '0;
        end else if (lk_acc) begin
            starve_d = starve_q + 1'b1;
        end
        pred_valid_d = lk_acc | fwd_acc;
        fwd_d        = fwd_acc;
        fwd_taken_d  = wr_ctr[1];
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_valid_q & (fwd_q ? fwd_taken_q : tbl_rdata[1]);
    assign busy       = (fifo_count != '0) | (state_q != IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            ctr_q        <= '0;
            run_q        <= 1'b0;
            pred_valid_q <= 1'b0;
            fwd_q        <= 1'b0;
            fwd_taken_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            ctr_q        <= ctr_d;
            run_q        <= run_d;
            pred_valid_q <= pred_valid_d;
            fwd_q        <= fwd_d;
            fwd_taken_q  <= fwd_taken_d;
        end
    end

endmodule

// File: tb/tb_bht_access_ctrl.sv
// Self-checking bench for bht_access_ctrl (default build, BHT_FWD_EN undefined).
module tb_bht_access_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       lk_valid, upd_valid, upd_taken;
    logic [4:0] lk_addr, upd_addr;
    logic       lk_ready, pred_valid, pred_taken, upd_ready;
    logic       tbl_en, tbl_we, busy;
    logic [4:0] tbl_addr;
    logic [1:0] tbl_wdata, tbl_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bht_access_ctrl #(
        .LOWER      (5),
        .FIFO_DEPTH (4),
        .STARVE_MAX (8)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .lk_valid   (lk_valid),
        .lk_addr    (lk_addr),
        .lk_ready   (lk_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_addr   (upd_addr),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .tbl_en     (tbl_en),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .tbl_rdata  (tbl_rdata),
        .busy       (busy)
    );

    // Synchronous single-port table the controller drives.
    logic [1:0] ram [32];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) ram[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= ram[tbl_addr];
        end
    end

    function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    // Reference: queue of pending updates, a remaining-phase count for the update
    // in progress, and a shadow table advanced when each update lands.
    typedef struct packed { logic [4:0] addr; logic taken; } upd_t;
    upd_t       mq[$];
    logic [1:0] ref_tbl [32];
    int         m_phase, m_starve;
    logic       e_lk_ready, e_upd_ready, e_busy, e_pred_valid, e_pred_taken, e_we;
    logic [4:0] e_waddr;
    logic [1:0] e_wdata;

    always @(posedge clk or negedge arst_n) begin : model
        logic acc_lk, acc_upd, popped, was_empty;
        if (!arst_n) begin
            mq.delete();
            m_phase = 0; m_starve = 0;
            e_lk_ready = 0; e_upd_ready = 0; e_busy = 0;
            e_pred_valid = 0; e_pred_taken = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
        end else begin
            acc_lk       = lk_valid && e_lk_ready;
            acc_upd      = upd_valid && e_upd_ready;
            was_empty    = (mq.size() == 0);
            e_pred_valid = acc_lk;
            e_pred_taken = acc_lk ? ref_tbl[lk_addr][1] : 1'b0;
            popped = 0;
            if (m_phase == 2) begin
                ref_tbl[mq[0].addr] = ref_sat(ref_tbl[mq[0].addr], mq[0].taken);
                void'(mq.pop_front());
                popped = 1; m_phase = 0;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (!acc_lk && !was_empty) begin
                m_phase = 1;
            end
            if (popped || was_empty) m_starve = 0;
            else if (acc_lk)         m_starve = m_starve + 1;
            if (acc_upd) mq.push_back('{addr: upd_addr, taken: upd_taken});
            e_lk_ready  = (m_phase == 0) && !((m_starve == 8) || (mq.size() == 4));
            e_upd_ready = (mq.size() < 4);
            e_busy      = (mq.size() != 0) || (m_phase != 0);
            e_we        = (m_phase == 2);
            e_waddr     = e_we ? mq[0].addr : 5'd0;
            e_wdata     = e_we ? ref_sat(ref_tbl[mq[0].addr], mq[0].taken) : 2'd0;
        end
    end

    task automatic preload(input int a, input logic [1:0] v);
        ram[a] = v;
        ref_tbl[a] = v;
    endtask

    task automatic idle_wait();
        lk_valid = 0; upd_valid = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_wait busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        preload(12, 2'b10);
        upd_valid = 1; upd_addr = 12; upd_taken = 1;
        @(negedge clk);
        upd_valid = 0;
        @(negedge clk);
        checks++;
        if ({busy, tbl_en} !== 2'b10) begin
            errors++; $display("FAIL reset_pre_rd busy/tbl_en=%b required 10", {busy, tbl_en});
        end
        arst_n = 0; lk_valid = 1; lk_addr = 3;
        #1;
        checks++;
        if ({lk_ready, pred_valid, pred_taken, upd_ready, tbl_en, tbl_we, tbl_addr, tbl_wdata, busy} !== 13'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0",
                     {lk_ready, pred_valid, pred_taken, upd_ready, tbl_en, tbl_we, tbl_addr, tbl_wdata, busy});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({tbl_en, tbl_we, busy, lk_ready} !== 4'b0) begin
                errors++; $display("FAIL reset_hold en/we/busy/rdy=%b required 0000", {tbl_en, tbl_we, busy, lk_ready});
            end
        end
        lk_valid = 0;
        arst_n = 1;
        @(negedge clk);
        checks++;
        if ({lk_ready, upd_ready, busy} !== 3'b110) begin
            errors++; $display("FAIL reset_release rdy/urdy/busy=%b required 110", {lk_ready, upd_ready, busy});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ram[12] !== 2'b10) begin
            errors++; $display("FAIL reset_no_write table[12]=%b required 10", ram[12]);
        end
    endtask

    task automatic test_lookup();
        idle_wait();
        preload(3, 2'b10); preload(7, 2'b01);
        lk_valid = 1; lk_addr = 3;
        #1;
        checks++;
        if ({lk_ready, tbl_en, tbl_we, tbl_addr} !== {3'b110, 5'd3}) begin
            errors++; $display("FAIL lookup_issue rdy/en/we/addr=%b required 110_00011", {lk_ready, tbl_en, tbl_we, tbl_addr});
        end
        @(negedge clk);
        checks++;
        if ({pred_valid, pred_taken} !== 2'b11) begin
            errors++; $display("FAIL lookup3 valid/taken=%b required 11", {pred_valid, pred_taken});
        end
        lk_addr = 7;
        @(negedge clk);
        checks++;
        if ({pred_valid, pred_taken} !== 2'b10) begin
            errors++; $display("FAIL lookup7 valid/taken=%b required 10", {pred_valid, pred_taken});
        end
        lk_valid = 0;
        @(negedge clk);
        checks++;
        if (pred_valid !== 1'b0) begin
            errors++; $display("FAIL lookup_pulse pred_valid=%b required 0", pred_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] expw [7];
        int idx, nw;
        expw = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        idle_wait();
        preload(9, 2'b11);
        idx = 0; nw = 0;
        for (int c = 0; c < 120 && nw < 7; c++) begin
            @(negedge clk);
            if (tbl_we) begin
                checks++;
                if (tbl_addr !== 5'd9 || tbl_wdata !== expw[nw]) begin
                    errors++;
                    $display("FAIL sat_write%0d addr=%0d wdata=%b required addr=9 wdata=%b", nw, tbl_addr, tbl_wdata, expw[nw]);
                end
                nw++;
            end
            if (idx < 7 && upd_ready) begin
                upd_valid = 1; upd_addr = 9; upd_taken = (idx < 3); idx++;
            end else begin
                upd_valid = 0;
            end
        end
        upd_valid = 0;
        checks++;
        if (nw != 7) begin
            errors++; $display("FAIL sat_count writes=%0d required 7", nw);
        end
    endtask

    task automatic test_starvation();
        int grants, lows, writes;
        idle_wait();
        lk_valid = 1; lk_addr = 5'($urandom_range(31, 0));
        upd_valid = 1; upd_addr = 5'($urandom_range(31, 0)); upd_taken = 1'($urandom);
        @(negedge clk);
        upd_valid = 0;
        grants = 0; lows = 0; writes = 0;
        for (int c = 0; c < 20; c++) begin
            if (!lk_ready) break;
            grants++;
            @(negedge clk);
            lk_addr = 5'($urandom_range(31, 0));
        end
        for (int c = 0; c < 10; c++) begin
            if (lk_ready) break;
            lows++;
            if (tbl_we) writes++;
            @(negedge clk);
        end
        checks++;
        if (grants != 8) begin errors++; $display("FAIL starve_grants got %0d required 8", grants); end
        checks++;
        if (lows != 3) begin errors++; $display("FAIL starve_stall got %0d required 3", lows); end
        checks++;
        if (writes != 1) begin errors++; $display("FAIL starve_write got %0d required 1", writes); end
        checks++;
        if (lk_ready !== 1'b1) begin errors++; $display("FAIL starve_resume lk_ready=%b required 1", lk_ready); end
        lk_valid = 0;
    endtask

    task automatic test_full();
        upd_t       items [5];
        logic [1:0] shadow [32];
        logic [1:0] expd [5];
        int idx, nw;
        bit full_seen;
        idle_wait();
        for (int i = 0; i < 32; i++) shadow[i] = ram[i];
        for (int i = 0; i < 5; i++) begin
            items[i].addr  = 5'($urandom_range(31, 0));
            items[i].taken = 1'($urandom);
            expd[i] = ref_sat(shadow[items[i].addr], items[i].taken);
            shadow[items[i].addr] = expd[i];
        end
        idx = 0; nw = 0; full_seen = 0;
        for (int c = 0; c < 150 && nw < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (idx == 4 && !full_seen) begin
                full_seen = 1;
                checks++;
                if (upd_ready !== 1'b0) begin errors++; $display("FAIL full_ready upd_ready=%b required 0", upd_ready); end
            end
            if (tbl_we) begin
                checks++;
                if (tbl_addr !== items[nw].addr || tbl_wdata !== expd[nw]) begin
                    errors++;
                    $display("FAIL full_write%0d addr=%0d wdata=%b required addr=%0d wdata=%b",
                             nw, tbl_addr, tbl_wdata, items[nw].addr, expd[nw]);
                end
                nw++;
            end
            lk_valid = 1; lk_addr = 5'($urandom_range(31, 0));
            if (idx < 5 && upd_ready) begin
                upd_valid = 1; upd_addr = items[idx].addr; upd_taken = items[idx].taken; idx++;
            end else begin
                upd_valid = 0;
            end
        end
        lk_valid = 0; upd_valid = 0;
        checks++;
        if (nw != 5 || !full_seen) begin
            errors++; $display("FAIL full_drain writes=%0d full_seen=%0d required 5 1", nw, full_seen);
        end
    endtask

    task automatic test_fwd_block();
        bit seen;
        idle_wait();
        preload(4, 2'b01);
        upd_valid = 1; upd_addr = 4; upd_taken = 1;
        @(negedge clk);
        upd_valid = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (tbl_we) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fwd_wr_seen tbl_we=0 required 1"); end
        lk_valid = 1; lk_addr = 4;
        #1;
        checks++;
        if (lk_ready !== 1'b0) begin errors++; $display("FAIL fwd_blocked lk_ready=%b required 0", lk_ready); end
        @(negedge clk);
        checks++;
        if ({pred_valid, lk_ready} !== 2'b01) begin
            errors++; $display("FAIL fwd_next pred_valid/lk_ready=%b required 01", {pred_valid, lk_ready});
        end
        @(negedge clk);
        lk_valid = 0;
        checks++;
        if ({pred_valid, pred_taken} !== 2'b11) begin
            errors++; $display("FAIL fwd_after valid/taken=%b required 11", {pred_valid, pred_taken});
        end
    endtask

    task automatic test_random();
        idle_wait();
        for (int a = 0; a < 32; a++) preload(a, 2'($urandom));
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (lk_ready !== e_lk_ready) begin errors++; $display("FAIL rnd_lk_ready c=%0d got %b required %b", c, lk_ready, e_lk_ready); end
            checks++;
            if (upd_ready !== e_upd_ready) begin errors++; $display("FAIL rnd_upd_ready c=%0d got %b required %b", c, upd_ready, e_upd_ready); end
            checks++;
            if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d got %b required %b", c, busy, e_busy); end
            checks++;
            if (pred_valid !== e_pred_valid) begin errors++; $display("FAIL rnd_pred_valid c=%0d got %b required %b", c, pred_valid, e_pred_valid); end
            if (e_pred_valid) begin
                checks++;
                if (pred_taken !== e_pred_taken) begin errors++; $display("FAIL rnd_pred_taken c=%0d got %b required %b", c, pred_taken, e_pred_taken); end
            end
            checks++;
            if (tbl_we !== e_we) begin errors++; $display("FAIL rnd_we c=%0d got %b required %b", c, tbl_we, e_we); end
            if (e_we) begin
                checks++;
                if (tbl_addr !== e_waddr || tbl_wdata !== e_wdata) begin
                    errors++; $display("FAIL rnd_write c=%0d addr=%0d wdata=%b required addr=%0d wdata=%b", c, tbl_addr, tbl_wdata, e_waddr, e_wdata);
                end
            end
            lk_valid  = (c % 100 < 50) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
            lk_addr   = 5'($urandom_range(7, 0));
            upd_valid = 1'($urandom);
            upd_addr  = 5'($urandom_range(7, 0));
            upd_taken = 1'($urandom);
        end
        lk_valid = 0; upd_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        arst_n = 0; lk_valid = 0; upd_valid = 0; upd_taken = 0;
        lk_addr = 0; upd_addr = 0;
        for (int a = 0; a < 32; a++) preload(a, 2'b00);
        repeat (3) @(negedge clk);
        arst_n = 1;
        test_reset();
        test_lookup();
        test_saturation();
        test_starvation();
        test_full();
        test_fwd_block();
        test_random();
        idle_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
